// File: rtl/wb_ibex_device_bridge.sv
// wb_ibex_device_bridge: pipelined Wishbone slave to Ibex-style device request/response bridge
module wb_ibex_device_bridge #(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [AddressWidth-1:0] wb_addr_i,
  input  logic [DataWidth-1:0]    wb_data_i,
  input  logic [DataWidth/8-1:0]  wb_sel_i,
  output logic                    wb_stall_o,
  output logic                    wb_ack_o,
  output logic [DataWidth-1:0]    wb_data_o,
  output logic                    wb_err_o,
  output logic                    device_req_o,
  output logic [AddressWidth-1:0] device_addr_o,
  output logic                    device_we_o,
  output logic [DataWidth/8-1:0]  device_be_o,
  output logic [DataWidth-1:0]    device_wdata_o,
  input  logic                    device_rvalid_i,
  input  logic [DataWidth-1:0]    device_rdata_i,
  input  logic                    device_err_i
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;
  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    accept, rsp, qual;
  logic                    ack_q, ack_d, err_q, err_d, req_q, req_d, we_q, we_d;
  logic [DataWidth-1:0]    rdata_q, rdata_d, wdata_q, wdata_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic [DataWidth/8-1:0]  be_q, be_d;
  assign wb_stall_o     = (cnt_q == 4'(MaxOutstanding)) | (state_q == DRAIN);
  assign accept         = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign rsp            = device_rvalid_i & (cnt_q != 4'd0);
  assign qual           = rsp & (state_q != DRAIN) & wb_cyc_i;
  assign wb_ack_o       = ack_q;
  assign wb_err_o       = err_q;
  assign wb_data_o      = rdata_q;
  assign device_req_o   = req_q;
  assign device_addr_o  = addr_q;
  assign device_we_o    = we_q;
  assign device_be_o    = be_q;
  assign device_wdata_o = wdata_q;
  // Capture request fields on accept, count outstanding, and forward qualified responses
  always_comb begin
    cnt_d   = cnt_q + 4'(accept) - 4'(rsp);
    req_d   = accept;
    addr_d  = accept ? wb_addr_i : addr_q;
    we_d    = accept ? wb_we_i : we_q;
    be_d    = accept ? wb_sel_i : be_q;
    wdata_d = accept ? wb_data_i : wdata_q;
    ack_d   = qual & ~device_err_i;
    err_d   = qual & device_err_i;
    rdata_d = qual ? device_rdata_i : rdata_q;
  end
  // Next state: an aborted cycle drains remaining responses silently before returning to idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? ACTIVE : IDLE;
      ACTIVE:  state_d = !wb_cyc_i ? ((cnt_d != 4'd0) ? DRAIN : IDLE) : ((cnt_d == 4'd0) ? IDLE : ACTIVE);
      DRAIN:   state_d = (cnt_d == 4'd0) ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end
endmodule
